// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared constants and types for the IF/ID stage
//
// Purpose : default word width, bubble encoding and counter width shared by
//           if_id_stage and its helpers, plus the instr_ID source enum.
// Ports   : none (package).

package if_pkg;

  localparam int            IF_DW        = 16;
  localparam logic [15:0]   IF_NOP_INSTR = 16'h0000;
  localparam int            IF_CNT_W     = 16;

  // Source of the word presented to decode this cycle.
  typedef enum logic [1:0] {
    SRC_MEM  = 2'd0,
    SRC_HOLD = 2'd1,
    SRC_NOP  = 2'd2
  } if_src_e;

endpackage

// File: rtl/sat_cntr.sv
// rtl/sat_cntr.sv - saturating up-counter with enable
//
// Purpose : counts cycles where en=1, sticks at all-ones, cleared by reset.
// Ports   : clk, rst_n (async, active-low), en (count this cycle),
//           count [W-1:0] (current value).

module sat_cntr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - instruction fetch to decode stage
//
// Purpose : picks the word shown to decode (memory data, stall hold register
//           or NOP bubble), squashes wrong-path fetches after a taken
//           branch/jump, covers the boot cycle, and redirects words read by
//           LWI (movc) to the DM/WB side.
//           Optional build macro: IF_PERF_CNT_EN adds bubble/stall counters.
// Ports   : clk, rst_n (async, active-low)
//           stall_IM_ID        - hazard stall, PC and IM_ID hold
//           flow_change_ID_EX  - taken branch/jump resolved this cycle
//           LWI_instr_EX_DM    - PC hijacked for a movc data read
//           im_rdata [DW]      - instruction memory data (1-cycle latency)
//           instr_ID [DW]      - word to decode (combinational)
//           instr_vld_ID       - 0 when instr_ID is an injected NOP
//           movc_data_DM_WB    - word returned for LWI
//           movc_vld_DM_WB     - one-cycle pulse qualifying movc_data_DM_WB
//           bubble_cnt, stall_cnt [CNT_W] - IF_PERF_CNT_EN only

module if_id_stage
  import if_pkg::*;
#(
  parameter int            DW        = IF_DW,
  parameter logic [DW-1:0] NOP_INSTR = IF_NOP_INSTR
`ifdef IF_PERF_CNT_EN
  , parameter int          CNT_W     = IF_CNT_W
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_IM_ID,
  input  logic             flow_change_ID_EX,
  input  logic             LWI_instr_EX_DM,
  input  logic [DW-1:0]    im_rdata,
  output logic [DW-1:0]    instr_ID,
  output logic             instr_vld_ID,
  output logic [DW-1:0]    movc_data_DM_WB,
  output logic             movc_vld_DM_WB
`ifdef IF_PERF_CNT_EN
  , output logic [CNT_W-1:0] bubble_cnt
  , output logic [CNT_W-1:0] stall_cnt
`endif
);

  logic          hold_sel;
  logic [DW-1:0] hold_reg;
  logic          squash_pend;
  logic          boot;
  logic          lwi_d1;
  if_src_e       src_sel;

  // Source select. An LWI word that arrives outside a stall is never decoded;
  // under a stall the hold register masks it anyway.
  always_comb begin
    src_sel = SRC_MEM;
    if (boot || flow_change_ID_EX || squash_pend || (lwi_d1 && !hold_sel)) begin
      src_sel = SRC_NOP;
    end else if (hold_sel) begin
      src_sel = SRC_HOLD;
    end
  end

  always_comb begin
    instr_ID     = im_rdata;
    instr_vld_ID = 1'b1;
    case (src_sel)
      SRC_NOP: begin
        instr_ID     = NOP_INSTR;
        instr_vld_ID = 1'b0;
      end
      SRC_HOLD: instr_ID = hold_reg;
      default:  instr_ID = im_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_sel        <= 1'b0;
      hold_reg        <= NOP_INSTR;
      squash_pend     <= 1'b0;
      boot            <= 1'b1;
      lwi_d1          <= 1'b0;
      movc_data_DM_WB <= '0;
      movc_vld_DM_WB  <= 1'b0;
    end else begin
      hold_sel    <= stall_IM_ID;
      boot        <= 1'b0;
      lwi_d1      <= LWI_instr_EX_DM;
      // A stall in the redirect cycle keeps the PC, so nothing needs squashing.
      squash_pend <= flow_change_ID_EX && !stall_IM_ID;
      // Tracks the shown word until a stall starts, then freezes on it.
      if (!hold_sel) begin
        hold_reg <= instr_ID;
      end
      movc_vld_DM_WB <= lwi_d1;
      if (lwi_d1) begin
        movc_data_DM_WB <= im_rdata;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  sat_cntr #(.W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (!instr_vld_ID),
    .count (bubble_cnt)
  );

  sat_cntr #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_IM_ID),
    .count (stall_cnt)
  );
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage

module tb_if_id_stage;

  logic        clk;
  logic        rst_n;
  logic        stall_IM_ID;
  logic        flow_change_ID_EX;
  logic        LWI_instr_EX_DM;
  logic [15:0] im_rdata;
  logic [15:0] instr_ID;
  logic        instr_vld_ID;
  logic [15:0] movc_data_DM_WB;
  logic        movc_vld_DM_WB;
`ifdef IF_PERF_CNT_EN
  logic [15:0] bubble_cnt;
  logic [15:0] stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  bit started  = 0;

  if_id_stage dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .stall_IM_ID       (stall_IM_ID),
    .flow_change_ID_EX (flow_change_ID_EX),
    .LWI_instr_EX_DM   (LWI_instr_EX_DM),
    .im_rdata          (im_rdata),
    .instr_ID          (instr_ID),
    .instr_vld_ID      (instr_vld_ID),
    .movc_data_DM_WB   (movc_data_DM_WB),
    .movc_vld_DM_WB    (movc_vld_DM_WB)
`ifdef IF_PERF_CNT_EN
    , .bubble_cnt      (bubble_cnt)
    , .stall_cnt       (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // Assert reset for two edges, release just after a rising edge: the time
  // until the next rising edge is cycle 0 (boot cycle).
  task automatic do_reset();
    rst_n = 1'b0;
    stall_IM_ID = 1'b0;
    flow_change_ID_EX = 1'b0;
    LWI_instr_EX_DM = 1'b0;
    im_rdata = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    started = 0;
  endtask

  // One cycle: advance to it, drive inputs, stop mid-cycle for checks.
  task automatic cyc(input logic s, input logic f, input logic l, input logic [15:0] rd);
    if (started) begin
      @(posedge clk);
      #1;
    end
    started = 1;
    stall_IM_ID       = s;
    flow_change_ID_EX = f;
    LWI_instr_EX_DM   = l;
    im_rdata          = rd;
    @(negedge clk);
  endtask

  initial begin
    // ---- Reset state and boot bubble ----
    do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_instr", instr_ID, 16'h0000);
    chk("rst_vld", instr_vld_ID, 0);
    chk("rst_movc_vld", movc_vld_DM_WB, 0);
    chk("rst_movc_data", movc_data_DM_WB, 16'h0000);
    do_reset();
    cyc(0, 0, 0, 16'h1234);
    chk("boot_c0_instr", instr_ID, 16'h0000);
    chk("boot_c0_vld", instr_vld_ID, 0);
    cyc(0, 0, 0, 16'h1234);
    chk("boot_c1_instr", instr_ID, 16'h1234);
    chk("boot_c1_vld", instr_vld_ID, 1);
`ifdef IF_PERF_CNT_EN
    chk("boot_bubble_cnt", bubble_cnt, 1);
`endif

    // ---- Stall hold/release ----
    do_reset();
    cyc(0, 0, 0, 16'h0BAD);
    cyc(0, 0, 0, 16'hA000);
    chk("st_c1", instr_ID, 16'hA000);
    cyc(1, 0, 0, 16'hA001);
    chk("st_c2", instr_ID, 16'hA001);
    cyc(1, 0, 0, 16'hA002);
    chk("st_c3", instr_ID, 16'hA001);
    chk("st_c3_vld", instr_vld_ID, 1);
    cyc(0, 0, 0, 16'hA002);
    chk("st_c4", instr_ID, 16'hA001);
    cyc(0, 0, 0, 16'hA002);
    chk("st_c5", instr_ID, 16'hA002);
    cyc(0, 0, 0, 16'hA003);
    chk("st_c6", instr_ID, 16'hA003);
`ifdef IF_PERF_CNT_EN
    chk("st_stall_cnt", stall_cnt, 2);
`endif

    // ---- Flow change: two bubbles, then re-arm ----
    do_reset();
    cyc(0, 0, 0, 16'h0000);
    cyc(0, 0, 0, 16'hB001);
    cyc(0, 0, 0, 16'hB002);
    cyc(0, 0, 0, 16'hB003);
    cyc(0, 0, 0, 16'hB004);
    cyc(0, 1, 0, 16'hB005);
    chk("fc_c5_instr", instr_ID, 16'h0000);
    chk("fc_c5_vld", instr_vld_ID, 0);
    cyc(0, 0, 0, 16'hB006);
    chk("fc_c6_vld", instr_vld_ID, 0);
    cyc(0, 0, 0, 16'hC000);
    chk("fc_c7_instr", instr_ID, 16'hC000);
    chk("fc_c7_vld", instr_vld_ID, 1);
`ifdef IF_PERF_CNT_EN
    chk("fc_bubble_cnt", bubble_cnt, 3);
`endif
    cyc(0, 1, 0, 16'hC001);
    chk("rearm_c8_vld", instr_vld_ID, 0);
    cyc(0, 1, 0, 16'hC002);
    chk("rearm_c9_vld", instr_vld_ID, 0);
    cyc(0, 0, 0, 16'hC003);
    chk("rearm_c10_vld", instr_vld_ID, 0);
    cyc(0, 0, 0, 16'hD000);
    chk("rearm_c11_instr", instr_ID, 16'hD000);

    // ---- LWI / movc ----
    do_reset();
    cyc(0, 0, 0, 16'h0000);
    cyc(0, 0, 0, 16'hE001);
    cyc(0, 0, 0, 16'hE002);
    cyc(1, 0, 1, 16'hE003);
    chk("lwi_c3_instr", instr_ID, 16'hE003);
    cyc(0, 0, 0, 16'hBEEF);
    chk("lwi_c4_instr", instr_ID, 16'hE003);
    chk("lwi_c4_vld", instr_vld_ID, 1);
    chk("lwi_c4_movc_vld", movc_vld_DM_WB, 0);
    cyc(0, 0, 0, 16'hE004);
    chk("lwi_c5_movc_vld", movc_vld_DM_WB, 1);
    chk("lwi_c5_movc_data", movc_data_DM_WB, 16'hBEEF);
    chk("lwi_c5_instr", instr_ID, 16'hE004);
    cyc(0, 0, 0, 16'hE005);
    chk("lwi_c6_movc_vld", movc_vld_DM_WB, 0);
    // back-to-back LWI in cycles 7 and 8
    cyc(1, 0, 1, 16'hE006);
    cyc(1, 0, 1, 16'h1111);
    cyc(0, 0, 0, 16'h2222);
    chk("b2b_c9_vld", movc_vld_DM_WB, 1);
    chk("b2b_c9_data", movc_data_DM_WB, 16'h1111);
    cyc(0, 0, 0, 16'hE007);
    chk("b2b_c10_vld", movc_vld_DM_WB, 1);
    chk("b2b_c10_data", movc_data_DM_WB, 16'h2222);
    cyc(0, 0, 0, 16'hE008);
    chk("b2b_c11_vld", movc_vld_DM_WB, 0);
    // LWI without the required stall: the word must still be bubbled
    cyc(0, 0, 1, 16'hE009);
    cyc(0, 0, 0, 16'h3333);
    chk("lwi_nostall_vld", instr_vld_ID, 0);
    chk("lwi_nostall_instr", instr_ID, 16'h0000);

    // ---- Flow change with stall in the same cycle ----
    do_reset();
    cyc(0, 0, 0, 16'h0000);
    cyc(0, 0, 0, 16'hF001);
    cyc(0, 0, 0, 16'hF002);
    cyc(0, 0, 0, 16'hF003);
    cyc(1, 1, 0, 16'hF004);
    chk("fcst_c4_vld", instr_vld_ID, 0);
    cyc(0, 0, 0, 16'hF004);
    chk("fcst_c5_instr", instr_ID, 16'h0000);
    chk("fcst_c5_vld", instr_vld_ID, 1);
    cyc(0, 0, 0, 16'hF005);
    chk("fcst_c6_instr", instr_ID, 16'hF005);

    // ---- Reset mid-stall with squash pending ----
    do_reset();
    cyc(0, 0, 0, 16'h0000);
    cyc(0, 0, 1, 16'h7001);
    cyc(0, 1, 0, 16'h7002);
    cyc(1, 0, 0, 16'h7003);
    chk("mid_c3_vld", instr_vld_ID, 0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_instr", instr_ID, 16'h0000);
    chk("mid_rst_vld", instr_vld_ID, 0);
    chk("mid_rst_movc_vld", movc_vld_DM_WB, 0);
    chk("mid_rst_movc_data", movc_data_DM_WB, 16'h0000);
`ifdef IF_PERF_CNT_EN
    chk("mid_rst_bubble_cnt", bubble_cnt, 0);
    chk("mid_rst_stall_cnt", stall_cnt, 0);
`endif
    do_reset();
    cyc(0, 0, 0, 16'h8000);
    chk("post_c0_vld", instr_vld_ID, 0);
    cyc(0, 0, 0, 16'h8001);
    chk("post_c1_instr", instr_ID, 16'h8001);
    chk("post_c1_vld", instr_vld_ID, 1);
    chk("post_c1_movc_vld", movc_vld_DM_WB, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
